mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, directly downstream of `execute`. It consumes the X/M pipeline register outputs, performs loads and stores over a variable-latency request/acknowledge data-memory port, and drives the M/W register. While an access is outstanding it stalls upstream and inserts bubbles into M/W. It also supplies the MEM-stage forwarding source.

---
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
// Takes the X/M register, performs loads/stores over a variable-latency
// req/ack data-memory port, and drives the M/W register. While an access is
// outstanding it stalls upstream and feeds bubbles into M/W.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   xm_*                     X/M pipeline register fields (inputs)
//   mem_stall                combinational stall for PC, F/D, D/X, X/M
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_rdata, dmem_ack     data-memory response
//   mw_*                     registered M/W pipeline register fields
//   fwd_valid/rd/data        combinational MEM-stage forwarding source
//   bus_err                  sticky, set when an access times out
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding; non-memory ops pass through in 1 cycle
// ST_WAIT | dmem_req held high, waiting for dmem_ack or the timeout

module mem_stage #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          xm_valid,
   input  logic          xm_mem_rd,
   input  logic          xm_mem_wr,
   input  logic [DW-1:0] xm_alu_result,
   input  logic [DW-1:0] xm_store_data,
   input  logic [3:0]    xm_rd,
   input  logic          xm_reg_wr,
   input  logic          xm_hlt,
   output logic          mem_stall,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic [DW-1:0] dmem_rdata,
   input  logic          dmem_ack,
   output logic          mw_valid,
   output logic          mw_reg_wr,
   output logic          mw_hlt,
   output logic [3:0]    mw_rd,
   output logic [DW-1:0] mw_data,
   output logic          fwd_valid,
   output logic [3:0]    fwd_rd,
   output logic [DW-1:0] fwd_data,
   output logic          bus_err
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state;
   logic [7:0] wcnt;      // wait cycles remaining before the access is abandoned
   logic       mem_op;
   logic       wcnt_tc;

   assign mem_op  = xm_valid & (xm_mem_rd | xm_mem_wr);
   assign wcnt_tc = (wcnt == 8'd0);

   // A loaded value is not available until M/W, so loads are not forwarded here.
   assign fwd_valid = xm_valid & xm_reg_wr & ~xm_mem_rd;
   assign fwd_rd    = xm_rd;
   assign fwd_data  = xm_alu_result;

   always_comb begin
      mem_stall = 1'b0;
      if (state == ST_IDLE) mem_stall = mem_op;
      else                  mem_stall = ~dmem_ack & ~wcnt_tc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         mw_valid   <= 1'b0;
         mw_reg_wr  <= 1'b0;
         mw_hlt     <= 1'b0;
         mw_rd      <= '0;
         mw_data    <= '0;
         bus_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_op) begin
                  state      <= ST_WAIT;
                  wcnt       <= TMO;
                  dmem_req   <= 1'b1;
                  dmem_we    <= xm_mem_wr;
                  dmem_addr  <= xm_alu_result;
                  dmem_wdata <= xm_store_data;
                  mw_valid   <= 1'b0;
                  mw_reg_wr  <= 1'b0;
                  mw_hlt     <= 1'b0;
               end else begin
                  mw_valid  <= xm_valid;
                  mw_reg_wr <= xm_reg_wr;
                  mw_hlt    <= xm_hlt;
                  mw_rd     <= xm_rd;
                  mw_data   <= xm_alu_result;
               end
            end
            ST_WAIT: begin
               if (dmem_ack || wcnt_tc) begin
                  // Completion: ack wins over a coincident timeout.
                  state     <= ST_IDLE;
                  dmem_req  <= 1'b0;
                  mw_valid  <= 1'b1;
                  mw_reg_wr <= xm_reg_wr;
                  mw_hlt    <= xm_hlt;
                  mw_rd     <= xm_rd;
                  if (dmem_ack) begin
                     mw_data <= dmem_we ? xm_alu_result : dmem_rdata;
                  end else begin
                     mw_data <= '0;
                     bus_err <= 1'b1;
                  end
               end else begin
                  wcnt      <= wcnt - 8'd1;
                  mw_valid  <= 1'b0;
                  mw_reg_wr <= 1'b0;
                  mw_hlt    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int DW  = 16;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          xm_valid, xm_mem_rd, xm_mem_wr, xm_reg_wr, xm_hlt;
   logic [DW-1:0] xm_alu_result, xm_store_data;
   logic [3:0]    xm_rd;
   logic          mem_stall, dmem_req, dmem_we, dmem_ack;
   logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic          mw_valid, mw_reg_wr, mw_hlt;
   logic [3:0]    mw_rd;
   logic [DW-1:0] mw_data;
   logic          fwd_valid;
   logic [3:0]    fwd_rd;
   logic [DW-1:0] fwd_data;
   logic          bus_err;

   int tests_run = 0;
   int failures  = 0;
   logic err_model = 1'b0;

   always #5 clk = ~clk;

   mem_stage #(.DW(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .xm_valid(xm_valid), .xm_mem_rd(xm_mem_rd), .xm_mem_wr(xm_mem_wr),
      .xm_alu_result(xm_alu_result), .xm_store_data(xm_store_data),
      .xm_rd(xm_rd), .xm_reg_wr(xm_reg_wr), .xm_hlt(xm_hlt),
      .mem_stall(mem_stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mw_valid(mw_valid), .mw_reg_wr(mw_reg_wr), .mw_hlt(mw_hlt),
      .mw_rd(mw_rd), .mw_data(mw_data),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .bus_err(bus_err)
   );

   typedef struct {
      logic v, rd_op, wr_op;
      logic [15:0] alu, sd;
      logic [3:0] rd;
      logic rw, hlt;
   } instr_t;

   typedef struct {
      int stalls, reqs;
      bit gap_bad, fields_bad, bubble_bad;
      logic req_after;
      logic fwd_valid;
      logic [3:0] fwd_rd;
      logic [15:0] fwd_data;
      logic mw_valid, mw_reg_wr, mw_hlt;
      logic [3:0] mw_rd;
      logic [15:0] mw_data;
      logic bus_err;
   } obs_t;

   typedef struct {
      int stalls;
      bit tmo;
      logic fwd_valid;
      logic mw_valid, mw_reg_wr, mw_hlt;
      logic [3:0] mw_rd;
      logic [15:0] mw_data;
   } exp_t;

   // Reference: a memory op costs k+1 stall cycles when acked k cycles after
   // req rises, or TMO+1 cycles and a zero result when the ack never comes in time.
   function automatic exp_t model(input instr_t i, input int k, input logic [15:0] rdata);
      exp_t e;
      bit mem;
      mem       = i.v && (i.rd_op || i.wr_op);
      e.tmo     = mem && (k < 0 || k > TMO);
      e.stalls  = !mem ? 0 : (e.tmo ? TMO + 1 : k + 1);
      e.mw_data = e.tmo ? 16'h0 : ((mem && i.rd_op) ? rdata : i.alu);
      e.mw_valid  = i.v;
      e.mw_reg_wr = i.rw;
      e.mw_hlt    = i.hlt;
      e.mw_rd     = i.rd;
      e.fwd_valid = i.v & i.rw & ~i.rd_op;
      return e;
   endfunction

   // Presents one instruction on X/M (held while stalled), plays the memory
   // with an ack k cycles after req rises (k<0: never), and records what happened.
   task automatic run_instr(input instr_t i, input int k, input logic [15:0] rdata, output obs_t o);
      int  cyc;
      bit  done;
      logic st;
      xm_valid = i.v; xm_mem_rd = i.rd_op; xm_mem_wr = i.wr_op;
      xm_alu_result = i.alu; xm_store_data = i.sd; xm_rd = i.rd;
      xm_reg_wr = i.rw; xm_hlt = i.hlt;
      #1;
      o.fwd_valid = fwd_valid; o.fwd_rd = fwd_rd; o.fwd_data = fwd_data;
      o.stalls = 0; o.reqs = 0;
      o.gap_bad = 0; o.fields_bad = 0; o.bubble_bad = 0;
      done = 0; cyc = 0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         if (cyc == 0 && dmem_req !== 1'b0) o.gap_bad = 1;
         if (dmem_req === 1'b1) begin
            o.reqs++;
            if (dmem_addr !== i.alu || dmem_we !== i.wr_op || dmem_wdata !== i.sd)
               o.fields_bad = 1;
            dmem_ack   = (o.reqs == k + 1);
            dmem_rdata = dmem_ack ? rdata : 16'($urandom);
         end else begin
            dmem_ack   = 1'($urandom);
            dmem_rdata = 16'($urandom);
         end
         #1 st = mem_stall;
         @(posedge clk); #1;
         cyc++;
         if (st === 1'b1) begin
            o.stalls++;
            if ((mw_valid | mw_reg_wr | mw_hlt) !== 1'b0) o.bubble_bad = 1;
         end else begin
            done = 1;
         end
      end
      dmem_ack = 1'b0;
      if (!done) begin
         tests_run++; failures++;
         $display("FAIL hang: no completion within 300 cycles (addr %h)", i.alu);
      end
      o.mw_valid = mw_valid; o.mw_reg_wr = mw_reg_wr; o.mw_hlt = mw_hlt;
      o.mw_rd = mw_rd; o.mw_data = mw_data; o.bus_err = bus_err;
      o.req_after = dmem_req;
   endtask

   task automatic test_reset();
      rst = 1'b1; xm_valid = 0; xm_mem_rd = 0; xm_mem_wr = 0; xm_reg_wr = 0; xm_hlt = 0;
      xm_alu_result = '0; xm_store_data = '0; xm_rd = '0; dmem_ack = 0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mw_valid, mw_reg_wr, mw_hlt, mw_rd, mw_data, bus_err, mem_stall} !== '0) begin
         failures++;
         $display("FAIL reset_state got req=%b we=%b addr=%h wd=%h mwv=%b mwrw=%b hlt=%b rd=%h data=%h err=%b stall=%b exp all 0",
                  dmem_req, dmem_we, dmem_addr, dmem_wdata, mw_valid, mw_reg_wr, mw_hlt, mw_rd, mw_data, bus_err, mem_stall);
      end
      rst = 1'b0;
      err_model = 1'b0;
   endtask

   // Shared table-driven body for the directed scenarios: each entry is one
   // instruction, its ack delay and the data memory returns.
   task automatic test_directed(input string name, input instr_t tab[], input int ks[], input logic [15:0] rds[]);
      obs_t o;
      exp_t e;
      foreach (tab[n]) begin
         e = model(tab[n], ks[n], rds[n]);
         run_instr(tab[n], ks[n], rds[n], o);
         err_model = err_model | e.tmo;
         tests_run++;
         if (o.stalls !== e.stalls) begin failures++;
            $display("FAIL %s[%0d] stall_cycles got=%0d exp=%0d", name, n, o.stalls, e.stalls); end
         tests_run++;
         if (o.reqs !== e.stalls) begin failures++;
            $display("FAIL %s[%0d] req_cycles got=%0d exp=%0d", name, n, o.reqs, e.stalls); end
         tests_run++;
         if ({o.gap_bad, o.fields_bad, o.bubble_bad, o.req_after} !== 4'b0000) begin failures++;
            $display("FAIL %s[%0d] req_gap/fields/bubble/req_after got=%b%b%b%b exp=0000",
                     name, n, o.gap_bad, o.fields_bad, o.bubble_bad, o.req_after); end
         tests_run++;
         if ({o.mw_valid, o.mw_reg_wr, o.mw_hlt, o.mw_rd} !== {e.mw_valid, e.mw_reg_wr, e.mw_hlt, e.mw_rd}) begin failures++;
            $display("FAIL %s[%0d] mw_ctrl got=%b%b%b/%h exp=%b%b%b/%h", name, n,
                     o.mw_valid, o.mw_reg_wr, o.mw_hlt, o.mw_rd, e.mw_valid, e.mw_reg_wr, e.mw_hlt, e.mw_rd); end
         tests_run++;
         if (o.mw_data !== e.mw_data) begin failures++;
            $display("FAIL %s[%0d] mw_data got=%h exp=%h", name, n, o.mw_data, e.mw_data); end
         tests_run++;
         if ({o.fwd_valid, o.fwd_rd, o.fwd_data} !== {e.fwd_valid, tab[n].rd, tab[n].alu}) begin failures++;
            $display("FAIL %s[%0d] fwd got=%b/%h/%h exp=%b/%h/%h", name, n,
                     o.fwd_valid, o.fwd_rd, o.fwd_data, e.fwd_valid, tab[n].rd, tab[n].alu); end
         tests_run++;
         if (o.bus_err !== err_model) begin failures++;
            $display("FAIL %s[%0d] bus_err got=%b exp=%b", name, n, o.bus_err, err_model); end
      end
   endtask

   task automatic test_alu();
      instr_t t[] = new[2];
      int ks[] = '{-1, -1};
      logic [15:0] rds[] = '{16'h0, 16'h0};
      t[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd3, 1'b1, 1'b0};
      t[1] = '{1'b1, 1'b0, 1'b0, 16'h8001, 16'h5555, 4'd9, 1'b0, 1'b1};
      test_directed("alu", t, ks, rds);
   endtask

   task automatic test_load();
      instr_t t[] = new[1];
      int ks[] = '{0};
      logic [15:0] rds[] = '{16'hBEEF};
      t[0] = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'h7777, 4'd5, 1'b1, 1'b0};
      test_directed("load_ack0", t, ks, rds);
   endtask

   task automatic test_store();
      instr_t t[] = new[1];
      int ks[] = '{5};
      logic [15:0] rds[] = '{16'h1111};
      t[0] = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'hA5A5, 4'd0, 1'b0, 1'b0};
      test_directed("store_ack5", t, ks, rds);
   endtask

   task automatic test_timeout();
      instr_t t[] = new[1];
      int ks[] = '{-1};
      logic [15:0] rds[] = '{16'h2222};
      t[0] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 4'd7, 1'b1, 1'b0};
      test_directed("timeout", t, ks, rds);
      // Late ack while idle must not produce a completion.
      xm_valid = 1'b0; xm_mem_rd = 1'b0; xm_mem_wr = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
      repeat (3) begin
         @(posedge clk); #1;
         tests_run++;
         if ({mw_valid, dmem_req, bus_err} !== 3'b001) begin failures++;
            $display("FAIL late_ack mwv/req/err got=%b%b%b exp=001", mw_valid, dmem_req, bus_err); end
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      xm_valid = 1'b1; xm_mem_rd = 1'b1; xm_mem_wr = 1'b0; xm_alu_result = 16'h0300;
      xm_reg_wr = 1'b1; xm_rd = 4'd2; xm_hlt = 1'b0; dmem_ack = 1'b0;
      @(posedge clk); #1;      // first WAIT cycle
      @(posedge clk); #1;      // second WAIT cycle
      rst = 1'b1; xm_valid = 1'b0; xm_mem_rd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      err_model = 1'b0;
      tests_run++;
      if ({dmem_req, mw_valid, mem_stall, bus_err} !== 4'b0000) begin failures++;
         $display("FAIL reset_in_wait req/mwv/stall/err got=%b%b%b%b exp=0000", dmem_req, mw_valid, mem_stall, bus_err); end
      test_alu();
   endtask

   task automatic test_back_to_back();
      instr_t t[] = new[2];
      int ks[] = '{2, 2};
      logic [15:0] rds[] = '{16'hC0DE, 16'hF00D};
      t[0] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 4'd1, 1'b1, 1'b0};
      t[1] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'd2, 1'b1, 1'b0};
      test_directed("back_to_back", t, ks, rds);
   endtask

   task automatic test_random();
      instr_t t[] = new[40];
      int ks[] = new[40];
      logic [15:0] rds[] = new[40];
      foreach (t[n]) begin
         int sel;
         sel = $urandom_range(0, 3);
         t[n].v     = (sel != 3);
         t[n].rd_op = (sel == 1) || (sel == 3 && $urandom_range(0, 1) == 1);
         t[n].wr_op = (sel == 2);
         t[n].alu   = 16'($urandom);
         t[n].sd    = 16'($urandom);
         t[n].rd    = 4'($urandom);
         t[n].rw    = 1'($urandom);
         t[n].hlt   = ($urandom_range(0, 7) == 0);
         ks[n]      = $urandom_range(0, TMO + 3) - 1;
         rds[n]     = 16'($urandom);
      end
      test_directed("random", t, ks, rds);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
